// File: rtl/avg_filter_nch.sv
// avg_filter_nch: per-channel 3x3 bypass/box/Gaussian filter over a framed pixel stream, 4-cycle latency.
module avg_filter_nch #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 720
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     filter_mode,
    input  logic                           pre_img_vsync,
    input  logic                           pre_img_hsync,
    input  logic                           pre_img_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] pre_img_data,
    output logic                           post_img_vsync,
    output logic                           post_img_hsync,
    output logic                           post_img_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] post_img_data,
    output logic [1:0]                     active_mode
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int AW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT + 1);
    localparam int SW = DW + 4;
    localparam int PW = SW + 13;
    localparam logic [1:0] BOX = 2'b01, GAU = 2'b10;

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic                   vs_d, va_d, vs_rise, va_fall, in_line, edge0;
    logic [AW-1:0]          addr;
    logic [DW-1:0]          lb0 [CHANNELS][IMG_WIDTH];
    logic [DW-1:0]          lb1 [CHANNELS][IMG_WIDTH];
    logic [DW-1:0]          rd0 [CHANNELS];
    logic [DW-1:0]          rd1 [CHANNELS];
    logic [DW-1:0]          win [CHANNELS][3][3];
    logic [DW+1:0]          rs  [CHANNELS][3];
    logic [SW-1:0]          tot [CHANNELS];
    logic [DW-1:0]          ctr2 [CHANNELS];
    logic [DW-1:0]          ctr3 [CHANNELS];
    logic [CHANNELS*DW-1:0] raw1, raw2, raw3, res;
    logic [3:0]             vs_sr, hs_sr, va_sr;
    logic [2:0]             edge_sr;
    logic [1:0]             mode1, mode2, mode3;

    function automatic logic [DW+1:0] row3(input logic [DW-1:0] a, b, c, input logic g);
        return (DW+2)'(a) + (DW+2)'(b) + (DW+2)'(c) + (g ? (DW+2)'(b) : '0);
    endfunction

    function automatic logic [SW-1:0] tot3(input logic [DW+1:0] a, b, c, input logic g);
        return SW'(a) + SW'(b) + SW'(c) + (g ? SW'(b) : '0);
    endfunction

    // 3641/32768 approximates 1/9 with rounding
    function automatic logic [DW-1:0] box_scale(input logic [SW-1:0] s);
        logic [PW-1:0] q;
        q = (PW'(s) * PW'(3641) + PW'(16384)) >> 15;
        return q > PW'({DW{1'b1}}) ? '1 : q[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] gau_scale(input logic [SW-1:0] g);
        return DW'((g + SW'(8)) >> 4);
    endfunction

    assign vs_rise = pre_img_vsync & ~vs_d;
    assign va_fall = va_d & ~pre_img_valid;
    assign in_line = col < CW'(IMG_WIDTH);
    assign addr    = in_line ? AW'(col) : '0;
    assign edge0   = row < RW'(2) || col < CW'(2) || !in_line;

    assign post_img_vsync = vs_sr[3];
    assign post_img_hsync = hs_sr[3];
    assign post_img_valid = va_sr[3];

    always_comb begin
        res = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rd0[i] = lb0[i][addr];
            rd1[i] = lb1[i][addr];
            res[i*DW +: DW] = edge_sr[2] ? raw3[i*DW +: DW] :
                              mode3 == BOX ? box_scale(tot[i]) :
                              mode3 == GAU ? gau_scale(tot[i]) : ctr3[i];
        end
    end

    always_ff @(posedge clk) begin
        if (pre_img_valid && in_line)
            for (int i = 0; i < CHANNELS; i++) begin
                lb0[i][addr] <= pre_img_data[i*DW +: DW];
                lb1[i][addr] <= rd0[i];
            end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col           <= '0;
            row           <= '0;
            vs_d          <= 1'b0;
            va_d          <= 1'b0;
            active_mode   <= '0;
            vs_sr         <= '0;
            hs_sr         <= '0;
            va_sr         <= '0;
            edge_sr       <= '0;
            mode1         <= '0;
            mode2         <= '0;
            mode3         <= '0;
            raw1          <= '0;
            raw2          <= '0;
            raw3          <= '0;
            post_img_data <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                for (int j = 0; j < 3; j++) begin
                    rs[i][j] <= '0;
                    for (int k = 0; k < 3; k++) win[i][j][k] <= '0;
                end
                tot[i]  <= '0;
                ctr2[i] <= '0;
                ctr3[i] <= '0;
            end
        end else begin
            vs_d <= pre_img_vsync;
            va_d <= pre_img_valid;
            if (vs_rise) active_mode <= (filter_mode == 2'b11) ? 2'b00 : filter_mode;
            if (va_fall) col <= '0;
            else if (pre_img_valid && in_line) col <= col + 1'b1;
            if (vs_rise) row <= '0;
            else if (va_fall && row < RW'(IMG_HEIGHT)) row <= row + 1'b1;
            vs_sr   <= {vs_sr[2:0], pre_img_vsync};
            hs_sr   <= {hs_sr[2:0], pre_img_hsync};
            va_sr   <= {va_sr[2:0], pre_img_valid};
            edge_sr <= {edge_sr[1:0], edge0};
            mode1   <= active_mode;
            mode2   <= mode1;
            mode3   <= mode2;
            raw1    <= pre_img_data;
            raw2    <= raw1;
            raw3    <= raw2;
            // the window only advances on real pixels so blanking never skews columns
            for (int i = 0; i < CHANNELS; i++) begin
                if (pre_img_valid) begin
                    for (int j = 0; j < 3; j++) begin
                        win[i][j][0] <= win[i][j][1];
                        win[i][j][1] <= win[i][j][2];
                    end
                    win[i][0][2] <= rd1[i];
                    win[i][1][2] <= rd0[i];
                    win[i][2][2] <= pre_img_data[i*DW +: DW];
                end
                for (int j = 0; j < 3; j++)
                    rs[i][j] <= row3(win[i][j][0], win[i][j][1], win[i][j][2], mode1 == GAU);
                ctr2[i] <= win[i][1][1];
                tot[i]  <= tot3(rs[i][0], rs[i][1], rs[i][2], mode2 == GAU);
                ctr3[i] <= ctr2[i];
            end
            post_img_data <= res;
        end
    end
endmodule

// File: tb/tb_avg_filter_nch.sv
// tb_avg_filter_nch: directed frames with random pixels checked against a frame-level reference model.
module tb_avg_filter_nch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  filter_mode = 2'b00;
    logic        pre_img_vsync = 1'b0, pre_img_hsync = 1'b0, pre_img_valid = 1'b0;
    logic [23:0] pre_img_data = '0;
    logic        post_img_vsync, post_img_hsync, post_img_valid;
    logic [23:0] post_img_data;
    logic [1:0]  active_mode;

    logic [23:0] img [8][20];
    logic [2:0]  hh [8192];
    logic [23:0] hd [8192];
    logic [1:0]  mm = 2'b00;
    logic        pvs = 1'b0;
    int          n = 0, checks = 0, errors = 0;

    avg_filter_nch #(.DATA_WIDTH(8), .CHANNELS(3), .IMG_WIDTH(16), .IMG_HEIGHT(8)) dut (
        .clk(clk), .rst_n(rst_n), .filter_mode(filter_mode),
        .pre_img_vsync(pre_img_vsync), .pre_img_hsync(pre_img_hsync),
        .pre_img_valid(pre_img_valid), .pre_img_data(pre_img_data),
        .post_img_vsync(post_img_vsync), .post_img_hsync(post_img_hsync),
        .post_img_valid(post_img_valid), .post_img_data(post_img_data),
        .active_mode(active_mode)
    );

    always #5 clk = ~clk;

    // reference: output of beat (r,c) is the 3x3 neighbourhood rows r-2..r, cols c-2..c
    function automatic logic [23:0] expect_px(input int r, input int c, input logic [1:0] m);
        logic [23:0] o;
        int s, g, q, v;
        o = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            g = 0;
            if (r < 2 || c < 2 || c >= 16) q = int'(img[r][c][ch*8 +: 8]);
            else begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++) begin
                        v = int'(img[r-2+dr][c-2+dc][ch*8 +: 8]);
                        s += v;
                        g += v * ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
                    end
                if (m == 2'd1) begin
                    q = (s * 3641 + 16384) >> 15;
                    if (q > 255) q = 255;
                end else if (m == 2'd2) q = (g + 8) >> 4;
                else q = int'(img[r-1][c-1][ch*8 +: 8]);
            end
            o[ch*8 +: 8] = q[7:0];
        end
        return o;
    endfunction

    task automatic cyc(input logic vs, input logic hs, input logic va, input logic [23:0] d, input logic [23:0] e);
        pre_img_vsync = vs;
        pre_img_hsync = hs;
        pre_img_valid = va;
        pre_img_data  = d;
        hh[n] = rst_n ? {vs, hs, va} : 3'b000;
        hd[n] = e;
        if (!rst_n)
            for (int k = 1; k <= 3; k++) if (n >= k) hh[n-k] = 3'b000;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (vs && !pvs) mm = (filter_mode == 2'd3) ? 2'd0 : filter_mode;
            pvs = vs;
        end else begin
            mm  = 2'd0;
            pvs = 1'b0;
        end
        if (n >= 3) begin
            checks++;
            assert ({post_img_vsync, post_img_hsync, post_img_valid} === hh[n-3]) else begin
                errors++;
                $error("FAIL sync cyc %0d got %b want %b", n, {post_img_vsync, post_img_hsync, post_img_valid}, hh[n-3]);
            end
            if (hh[n-3][0]) begin
                checks++;
                assert (post_img_data === hd[n-3]) else begin
                    errors++;
                    $error("FAIL data cyc %0d got %h want %h", n, post_img_data, hd[n-3]);
                end
            end
        end
        if (!rst_n) begin
            checks++;
            assert (post_img_data === 24'h0) else begin
                errors++;
                $error("FAIL rst_data cyc %0d got %h want 0", n, post_img_data);
            end
        end
        checks++;
        assert (active_mode === mm) else begin
            errors++;
            $error("FAIL mode cyc %0d got %0d want %0d", n, active_mode, mm);
        end
        n++;
    endtask

    task automatic frame(input int kind, input int len, input logic [1:0] fm,
                         input int sw_line, input logic [1:0] fm2, input int rst_line);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 20; c++)
                img[r][c] = (kind == 1) ? 24'h646464 : (kind == 2) ? ((r == 4 && c == 4) ? 24'hFFFFFF : 24'h0)
                                                                  : 24'($urandom);
        filter_mode = fm;
        cyc(0, 0, 0, '0, '0);
        cyc(1, 0, 0, '0, '0);
        cyc(1, 0, 0, '0, '0);
        cyc(0, 0, 0, '0, '0);
        for (int r = 0; r < 8; r++) begin
            if (r == sw_line) filter_mode = fm2;
            cyc(0, 1, 0, '0, '0);
            for (int c = 0; c < len; c++) begin
                if (r == rst_line && c == len / 2) begin
                    rst_n = 1'b0;
                    cyc(0, 0, 1, img[r][c], '0);
                    cyc(0, 0, 1, img[r][c+1], '0);
                    rst_n = 1'b1;
                    for (int k = 0; k < 5; k++) cyc(0, 0, 0, '0, '0);
                    return;
                end
                cyc(0, 0, 1, img[r][c], expect_px(r, c, mm));
            end
            for (int k = 0; k < 3; k++) cyc(0, 0, 0, '0, '0);
        end
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, '0, '0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, '0, '0);
        rst_n = 1'b1;
        cyc(0, 0, 0, '0, '0);
        frame(1, 16, 2'd1, -1, 2'd0, -1);
        frame(2, 16, 2'd1, -1, 2'd0, -1);
        frame(2, 16, 2'd2, -1, 2'd0, -1);
        frame(0, 16, 2'd1, 3, 2'd2, -1);
        frame(0, 16, 2'd2, -1, 2'd0, -1);
        frame(0, 20, 2'd1, -1, 2'd0, -1);
        frame(0, 20, 2'd2, -1, 2'd0, -1);
        frame(0, 16, 2'd0, -1, 2'd0, -1);
        frame(0, 16, 2'd3, -1, 2'd0, -1);
        frame(0, 16, 2'd1, -1, 2'd0, 3);
        frame(0, 16, 2'd1, -1, 2'd0, -1);
        frame(0, 16, 2'd2, -1, 2'd0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avg_filter_nch.md
# avg_filter_nch

Parametrised successor to the single-channel 3x3 mean filter in the image-processing chain. It sits between the capture/colour-conversion stages and downstream edge or threshold blocks. It accepts a CHANNELS-wide pixel stream with vsync/hsync/valid framing and builds its own 3x3 windows from internal line buffers. Each channel is filtered independently in a frame-selectable mode (bypass, box mean, 1-2-1 Gaussian) with fixed 4-cycle latency.

## Interface
- DATA_WIDTH, 8, bits per channel sample
- CHANNELS, 3, number of independent channels packed in the data bus (channel 0 in LSBs)
- IMG_WIDTH, 1280, active pixels per line; line-buffer depth
- IMG_HEIGHT, 720, active lines per frame; sizes the row counter
- clk  input  1  sole clock
- rst_n  input  1  reset; synchronous, active-low
- filter_mode  input  2  00 bypass, 01 box mean, 10 Gaussian, 11 reserved (treated as bypass)
- pre_img_vsync  input  1  frame sync
- pre_img_hsync  input  1  line sync
- pre_img_valid  input  1  active pixel strobe
- pre_img_data  input  CHANNELS*DATA_WIDTH  input pixel
- post_img_vsync  output  1  pre_img_vsync delayed 4 cycles
- post_img_hsync  output  1  pre_img_hsync delayed 4 cycles
- post_img_valid  output  1  pre_img_valid delayed 4 cycles
- post_img_data  output  CHANNELS*DATA_WIDTH  filtered pixel
- active_mode  output  2  mode in force for the current frame

## Operation
- Reset (rst_n=0 at a clk edge): all post_* outputs, active_mode, the row/col counters and the pipeline registers go to 0. Line-buffer RAM is not cleared.
- Mode latch: on a rising edge of pre_img_vsync (previous sample 0, current sample 1), active_mode <= filter_mode, with 11 mapped to 00. Mid-frame changes to filter_mode are ignored.
- Counters:
  - col increments on every valid beat and clears on the falling edge of pre_img_valid.
  - row increments on each valid falling edge (capped at IMG_HEIGHT) and clears on the vsync rising edge.
- Line buffers: two per channel, depth IMG_WIDTH, addressed by col. On a valid beat with col < IMG_WIDTH:
  - read the two stored lines;
  - write line0 <= input and line1 <= old line0.
- Window: three 3-deep column shift registers per channel, holding rows r-2..r and columns c-2..c of input beat (r,c). The centre p22 is pixel (r-1,c-1).
- Edge rule: beat (r,c) is an edge beat if r<2, c<2 or c>=IMG_WIDTH. Edge beats output input pixel (r,c) unmodified, delayed 4 cycles. Beats with col >= IMG_WIDTH do not write the line buffers.
- Interior beats carry the result centred at (r-1,c-1), i.e. a one-pixel down-right offset. The golden model uses exactly this mapping.
- Arithmetic, per channel, bit-exact:
  - Box: S = sum of 9 taps (DATA_WIDTH+4 bits). out = (S*3641 + 16384) >> 15, saturated to 2^DATA_WIDTH-1.
  - Gaussian: G = p11+p13+p31+p33 + 2(p12+p21+p23+p32) + 4p22. out = (G + 8) >> 4. No saturation is needed.
  - Bypass: out = p22 for interior beats. Edge beats still follow the edge rule.
- Non-valid cycles: post_img_data is don't-care, but the pipeline keeps shifting.

## Timing
- Pipeline (input at cycle t, output at t+4):
  - t+1: window/tap registers
  - t+2: row partial sums
  - t+3: total sum
  - t+4: scale/round/select into the output register
- The sync and valid signals pass through an identical 4-stage delay, so all outputs are aligned. The edge flag and the raw pixel are delayed alongside.
- Throughput: one pixel per clk. Back-to-back valid beats with no blanking are supported.
- active_mode updates 1 cycle after the vsync rising edge. Data already in the pipeline completes with the mode in force at its input cycle, so the mode is registered per stage.
- Reset mid-frame: outputs read 0 from the next edge. After release, the first two lines of any frame are edge beats, so stale RAM contents never reach the output.
- Simultaneous vsync rise and valid fall: row clears; the clear takes priority over the increment.

## Test plan
- Flat field, 8-bit, CHANNELS=3, IMG_WIDTH=16, 8 lines, all channels = 100, box mode. Required: every output = 100, and post_img_valid = pre_img_valid delayed exactly 4 cycles.
- Single impulse of 255 at (4,4), others 0, box mode. Required:
  - beats (4..6, 4..6) output 28 ((2295... S=255, 255*3641+16384 >> 15 = 28));
  - all other interior beats 0;
  - edge beats pass their raw input.
- Same impulse, Gaussian mode. Required: beat (5,5) = 64, (5,4) and (4,5) = 32, (4,4) = 16.
- Mode change: filter_mode switched from 01 to 10 mid-frame. Required: active_mode stays 01 until the next vsync rise, then reads 10; the next frame matches the Gaussian golden model.
- Line overrun: 20 valid beats on lines with IMG_WIDTH=16. Required: beats 16..19 pass through raw, and the next line's window uses only the first 16 stored pixels.
- Reset at mid-frame line 3. Required: all outputs 0 one cycle after the rst_n=0 edge. The first post-reset frame's lines 0-1 are raw pass-through, and it is otherwise bit-exact with the golden model.
